uart_rxr: RTL and testbench
===========================

# uart_rxr

Serial-to-parallel UART receiver, 8N1, LSB first. It is the downstream partner of the transmitter: it consumes a transmitter's serial `o_dataline` (loopback, or the external RX pin) and presents each received byte with a one-cycle valid strobe. It runs on the same single clock and uses the same `CLKS_PER_BIT` baud convention as the transmitter. It also detects start-bit glitches and framing errors, and holds off after a line break.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit. Legal range is 4..1023.
- `i_clk`  in  1  single system clock. All logic is on its rising edge.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_dataline`  in  1  serial input, asynchronous to `i_clk`. Idles high.
- `o_byte`  out  8  last correctly framed byte. Reset value 8'h00.
- `o_data_valid`  out  1  one-cycle pulse when `o_byte` updates. Reset value 0.
- `o_framing_error`  out  1  one-cycle pulse when the stop bit is sampled low. Reset value 0.
- `o_busy`  out  1  high in every state except IDLE. Reset value 0.

## Operation
- The input passes through a 2-FF synchronizer whose flops reset to 1. All decisions use the synchronized bit `rx_s`.
- `HALF` = (CLKS_PER_BIT-1)/2, integer division. `clk_ctr` is $clog2(CLKS_PER_BIT) bits wide. `bit_ctr` is 3 bits.
- States and transitions:
  - IDLE: when `rx_s`==0, go to START and clear `clk_ctr`.
  - START: `clk_ctr` increments each cycle.
    - When `clk_ctr`==HALF: if `rx_s`==0, go to DATA and clear `clk_ctr`.
    - Otherwise go to IDLE. This is a glitch: no strobe and no error.
  - DATA: `clk_ctr` increments each cycle.
    - When `clk_ctr`==CLKS_PER_BIT-1, clear `clk_ctr` and write `rx_s` into `shift[bit_ctr]`, then increment `bit_ctr`.
    - After bit 7 is sampled, `bit_ctr` wraps to 0 and the state goes to STOP.
  - STOP: when `clk_ctr`==CLKS_PER_BIT-1:
    - If `rx_s`==1: load `o_byte` from `shift`, pulse `o_data_valid`, go to CLEANUP.
    - If `rx_s`==0: pulse `o_framing_error`, leave `o_byte` unchanged, go to BREAK_WAIT.
  - CLEANUP: one cycle, then IDLE.
  - BREAK_WAIT: stay until `rx_s`==1, then go to IDLE. A held-low line therefore never produces back-to-back false frames.
- `o_data_valid` and `o_framing_error` are never high in the same cycle.
- Reset asserted mid-frame: every register returns to its reset value immediately and the partial frame is discarded. After release, a frame is accepted only after a fresh high-to-low edge is seen through the synchronizer.
- `shift` is not cleared between frames. Every bit of it is overwritten before use.

## Timing
- Let E0 be the first `i_clk` edge at which the synchronizer stage 1 captures `i_dataline`==0.
- The start bit is sampled at edge E0+HALF+3.
- Data bit n (n=0..7) is sampled at edge E0+HALF+3+(n+1)·CLKS_PER_BIT.
- The stop bit is sampled at edge E0+HALF+3+9·CLKS_PER_BIT. `o_data_valid` or `o_framing_error` is high for the one cycle following that edge.
- With CLKS_PER_BIT=16 (HALF=7), the strobe follows edge E0+154.
- Back-to-back frames are supported. The next start edge may arrive immediately after the stop-bit sample, because CLEANUP (1 cycle) plus sync latency (2 cycles) fits inside the half stop bit that remains.
- No back-pressure: a consumer must capture `o_byte` on the strobe. `o_byte` is held stable until the next valid strobe.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding, a 3-bit enum (IDLE, START, DATA, STOP, CLEANUP, BREAK_WAIT), shared in naming with the transmitter's states;
  - the default `CLKS_PER_BIT`;
  - the frame constants `DATA_BITS`=8 and `STOP_BITS`=1.
- Sub-module `uart_sync_2ff`: 2-flop synchronizer with a reset-value parameter (here 1). It is reusable for other asynchronous pins.
- Elaboration check: fail if CLKS_PER_BIT < 4.

## Test plan
- Loopback at CLKS_PER_BIT=16: a transmitter sends 8'hA5. One `o_data_valid` pulse occurs, `o_byte`=8'hA5, `o_framing_error` stays 0, and the strobe timing matches the Timing section.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap: exactly three valid strobes, in order, with no errors.
- Low glitch of 5 cycles on an idle line: the receiver returns to IDLE, and no `o_data_valid` or `o_framing_error` pulse occurs.
- Frame 8'h81 with the stop bit forced low, then the line held low for 100 bit times: exactly one `o_framing_error` pulse, `o_byte` keeps its previous value, `o_busy` stays high until the line returns high, then a following 8'h55 is received correctly.
- `i_rst` pulsed during data bit 4 of a frame: all outputs go to reset values in the same cycle, and the rest of that frame produces no strobe unless a later start edge occurs.
- CLKS_PER_BIT=434 with input bit times skewed ±3%: 8'hC3 is received without error.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_t     - FSM state encoding (same names on both sides)
//   CLKS_PER_BIT_DEF - default clock cycles per serial bit
//   DATA_BITS        - data bits per frame (8N1)
//   STOP_BITS        - stop bits per frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP,
        BREAK_WAIT
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;

endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
//   RST_VAL - value both flops take during reset (the idle level of the pin)
//   i_clk   - destination clock
//   i_rst   - asynchronous active-high reset
//   i_d     - asynchronous input
//   o_q     - synchronized output, two i_clk edges behind i_d
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rxr.sv
// uart_rxr: 8N1 UART receiver, LSB first, single clock domain.
//   CLKS_PER_BIT    - clock cycles per serial bit (4..1023)
//   i_clk           - system clock, rising edge
//   i_rst           - asynchronous active-high reset
//   i_dataline      - serial input, idles high, asynchronous to i_clk
//   o_byte          - last correctly framed byte, held until the next one
//   o_data_valid    - one-cycle pulse when o_byte updates
//   o_framing_error - one-cycle pulse when the stop bit is sampled low
//   o_busy          - high whenever the FSM is not in IDLE
module uart_rxr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_dataline,
    output logic [7:0] o_byte,
    output logic       o_data_valid,
    output logic       o_framing_error,
    output logic       o_busy
);

    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 1023) begin : g_bad_cpb
        $error("uart_rxr: CLKS_PER_BIT must be in 4..1023");
    end
    if (DATA_BITS != 8 || STOP_BITS != 1) begin : g_bad_frame
        $error("uart_rxr: only 8N1 framing is implemented");
    end

    uart_state_t   r_state;
    uart_state_t   w_next;
    logic [CW-1:0] r_clk_ctr;
    logic [2:0]    r_bit_ctr;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_ferr;

    logic w_rx;
    logic w_ctr_clr;
    logic w_ctr_inc;
    logic w_sample;
    logic w_load;
    logic w_ferr;

    // Sync flops reset to the idle level, so a reset never looks like a start edge
    // unless the line is genuinely low afterwards.
    uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_dataline),
        .o_q   (w_rx)
    );

    always_comb begin
        w_next    = r_state;
        w_ctr_clr = 1'b0;
        w_ctr_inc = 1'b0;
        w_sample  = 1'b0;
        w_load    = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_next    = START;
                    w_ctr_clr = 1'b1;
                end
            end
            START: begin
                // Re-check the line in mid start bit; a high here was a glitch.
                if (r_clk_ctr == C_HALF) begin
                    w_ctr_clr = 1'b1;
                    w_next    = w_rx ? IDLE : DATA;
                end else begin
                    w_ctr_inc = 1'b1;
                end
            end
            DATA: begin
                if (r_clk_ctr == C_LAST) begin
                    w_ctr_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_bit_ctr == B_LAST) w_next = STOP;
                end else begin
                    w_ctr_inc = 1'b1;
                end
            end
            STOP: begin
                if (r_clk_ctr == C_LAST) begin
                    w_ctr_clr = 1'b1;
                    if (w_rx) begin
                        w_load = 1'b1;
                        w_next = CLEANUP;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = BREAK_WAIT;
                    end
                end else begin
                    w_ctr_inc = 1'b1;
                end
            end
            CLEANUP:    w_next = IDLE;
            // Hold off until the line returns high so a break is one error, not many.
            BREAK_WAIT: if (w_rx) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_ctr <= '0;
            r_bit_ctr <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (w_ctr_clr)      r_clk_ctr <= '0;
            else if (w_ctr_inc) r_clk_ctr <= r_clk_ctr + CW'(1);
            if (w_sample) begin
                r_shift[r_bit_ctr] <= w_rx;
                r_bit_ctr          <= r_bit_ctr + 3'd1;
            end
            if (w_load) r_byte <= r_shift;
            r_valid <= w_load;
            r_ferr  <= w_ferr;
        end
    end

    assign o_byte          = r_byte;
    assign o_data_valid    = r_valid;
    assign o_framing_error = r_ferr;
    assign o_busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rxr.sv
module tb_uart_rxr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst16, rst434, line16, line434;
    logic [7:0] byte16, byte434;
    logic       v16, f16, b16, v434, f434, b434;

    uart_rxr #(.CLKS_PER_BIT(16)) dut16 (
        .i_clk(clk), .i_rst(rst16), .i_dataline(line16),
        .o_byte(byte16), .o_data_valid(v16), .o_framing_error(f16), .o_busy(b16)
    );

    uart_rxr #(.CLKS_PER_BIT(434)) dut434 (
        .i_clk(clk), .i_rst(rst434), .i_dataline(line434),
        .o_byte(byte434), .o_data_valid(v434), .o_framing_error(f434), .o_busy(b434)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q16[$];
    logic [7:0] q434[$];
    int nv16 = 0, nf16 = 0, nv434 = 0, nf434 = 0, last_v16 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe pops the oldest expected byte.
    always @(negedge clk) begin
        if (v16 === 1'b1) begin
            nv16++;
            last_v16 = cyc;
            check("rx16_sb_nonempty", 32'(q16.size() > 0), 32'd1);
            if (q16.size() > 0) check("rx16_byte", 32'(byte16), 32'(q16.pop_front()));
        end
        if (f16 === 1'b1) nf16++;
        if (v16 === 1'b1 || f16 === 1'b1) check("rx16_excl", 32'(v16 & f16), 32'd0);
        if (v434 === 1'b1) begin
            nv434++;
            check("rx434_sb_nonempty", 32'(q434.size() > 0), 32'd1);
            if (q434.size() > 0) check("rx434_byte", 32'(byte434), 32'(q434.pop_front()));
        end
        if (f434 === 1'b1) nf434++;
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx16(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            line16 = fr[i];
            idle(16);
        end
    endtask

    task automatic tx434(input logic [7:0] d, input int bitlen);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            line434 = fr[i];
            idle(bitlen);
        end
    endtask

    initial begin
        int t0, nv0, nf0;
        logic [9:0] fr;
        rst16 = 1'b1; rst434 = 1'b1; line16 = 1'b1; line434 = 1'b1;
        idle(3);
        check("rst_byte", 32'(byte16), 32'h00);
        check("rst_valid", 32'(v16), 32'd0);
        check("rst_ferr", 32'(f16), 32'd0);
        check("rst_busy", 32'(b16), 32'd0);
        check("rst434_busy", 32'(b434), 32'd0);
        rst16 = 1'b0; rst434 = 1'b0;
        idle(5);

        // Single frame with strobe timing: E0 is the next edge after the line falls.
        t0 = cyc + 1;
        q16.push_back(8'hA5);
        tx16(8'hA5, 1'b1);
        idle(20);
        check("a5_count", 32'(nv16), 32'd1);
        check("a5_ferr", 32'(nf16), 32'd0);
        check("a5_timing", last_v16, t0 + 154);
        check("a5_hold", 32'(byte16), 32'hA5);
        check("a5_idle", 32'(b16), 32'd0);

        // Back-to-back frames, no gap.
        nv0 = nv16;
        q16.push_back(8'h00); q16.push_back(8'hFF); q16.push_back(8'h3C);
        tx16(8'h00, 1'b1);
        tx16(8'hFF, 1'b1);
        tx16(8'h3C, 1'b1);
        idle(20);
        check("b2b_count", nv16 - nv0, 32'd3);
        check("b2b_ferr", 32'(nf16), 32'd0);
        check("b2b_sb_empty", 32'(q16.size()), 32'd0);

        // Short low glitch on idle line.
        nv0 = nv16;
        line16 = 1'b0;
        idle(5);
        line16 = 1'b1;
        idle(50);
        check("glitch_valid", nv16 - nv0, 32'd0);
        check("glitch_ferr", 32'(nf16), 32'd0);
        check("glitch_busy", 32'(b16), 32'd0);

        // Stop bit low followed by a long break.
        nv0 = nv16;
        tx16(8'h81, 1'b0);
        idle(100 * 16);
        check("brk_ferr", 32'(nf16), 32'd1);
        check("brk_valid", nv16 - nv0, 32'd0);
        check("brk_byte", 32'(byte16), 32'h3C);
        check("brk_busy", 32'(b16), 32'd1);
        line16 = 1'b1;
        idle(20);
        check("brk_release", 32'(b16), 32'd0);
        q16.push_back(8'h55);
        tx16(8'h55, 1'b1);
        idle(20);
        check("brk_after_count", nv16 - nv0, 32'd1);
        check("brk_after_byte", 32'(byte16), 32'h55);

        // Reset in the middle of data bit 4 (line high from there to the stop bit).
        nv0 = nv16;
        fr = {1'b1, 8'hF0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            line16 = fr[i];
            idle(16);
        end
        line16 = fr[5];
        idle(8);
        check("mid_busy", 32'(b16), 32'd1);
        rst16 = 1'b1;
        #1;
        check("mid_rst_byte", 32'(byte16), 32'h00);
        check("mid_rst_busy", 32'(b16), 32'd0);
        check("mid_rst_valid", 32'(v16), 32'd0);
        check("mid_rst_ferr", 32'(f16), 32'd0);
        idle(1);
        rst16 = 1'b0;
        idle(8 + 16 * 4);
        idle(40);
        check("mid_no_strobe", nv16 - nv0, 32'd0);
        check("mid_idle", 32'(b16), 32'd0);
        check("mid_byte_kept", 32'(byte16), 32'h00);
        q16.push_back(8'h96);
        tx16(8'h96, 1'b1);
        idle(20);
        check("mid_recover", nv16 - nv0, 32'd1);
        check("total_ferr", 32'(nf16), 32'd1);

        // Default baud divisor with +/-3% bit-time skew.
        q434.push_back(8'hC3); q434.push_back(8'hC3);
        tx434(8'hC3, 447);
        idle(868);
        tx434(8'hC3, 421);
        idle(868);
        check("skew_count", 32'(nv434), 32'd2);
        check("skew_ferr", 32'(nf434), 32'd0);
        check("skew_byte", 32'(byte434), 32'hC3);
        check("skew_idle", 32'(b434), 32'd0);
        check("sb16_empty", 32'(q16.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
